// File: rtl/seq_mul_hs.sv
// seq_mul_hs: sequential shift-add multiplier with valid/ready handshakes.
//
// Consumes one multiplier bit per clock and returns the full 2*WIDTH-bit
// product. Each operation selects signed (two's complement) or unsigned mode.
// Signed operands are reduced to magnitudes on capture. The product is negated
// on the last BUSY edge when the operand signs differ.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    producer presents in_a/in_b/in_signed
//   in_ready    block can accept an operation (high only in IDLE)
//   in_a        multiplicand, WIDTH bits
//   in_b        multiplier, WIDTH bits
//   in_signed   1: two's complement operands/product, 0: unsigned
//   out_valid   out_product holds a completed result (DONE)
//   out_ready   consumer accepts the result
//   out_product 2*WIDTH-bit product, held until consumed
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer may change or drop its payload while ready is low. out_valid
// and out_product stay stable from the moment out_valid rises until the
// transfer.
//
// The FSM state is available as the internal signal state_q (type state_t).

module seq_mul_hs #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   prod_q, prod_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_sum;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    prod_d   = prod_q;

    // Negating -2^(WIDTH-1) gives 2^(WIDTH-1) again. Read as an unsigned
    // value, that is the exact magnitude, so no extra bit is needed.
    a_mag = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    b_mag = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;

    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // The last add and the sign fix-up share this edge. This keeps the
          // latency at exactly WIDTH cycles.
          prod_d  = neg_q ? -acc_sum : acc_sum;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign out_product = prod_q;

endmodule

// File: tb/tb_seq_mul_hs.sv
// tb_seq_mul_hs: randomized, self-checking bench for seq_mul_hs.
//
// Instance u8 runs with WIDTH=8 and carries most of the stimulus. Instance u16
// runs with WIDTH=16 and covers the wide corner cases. Expected products come
// from plain integer multiplication of the sign-extended operands. They are
// queued on acceptance and popped when the result is consumed.

module tb_seq_mul_hs;

  localparam int W  = 8;
  localparam int WH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic            in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [W-1:0]    in_a, in_b;
  logic [2*W-1:0]  out_product;

  logic            h_in_valid, h_in_ready, h_in_signed, h_out_valid, h_out_ready;
  logic [WH-1:0]   h_in_a, h_in_b;
  logic [2*WH-1:0] h_out_product;

  seq_mul_hs #(.WIDTH(W)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product)
  );

  seq_mul_hs #(.WIDTH(WH)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_in_a), .in_b(h_in_b), .in_signed(h_in_signed),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_product(h_out_product)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  int last_acc_cyc = -1000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: sign-extend when signed, multiply as integers, keep 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input bit s);
    longint x, y, p, mask;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    mask = (longint'(1) << (2 * w)) - 1;
    return 64'(p & mask);
  endfunction

  // ---------------- drivers ----------------
  // Runs one WIDTH=8 operation. During BUSY the task drives random junk on the
  // producer side and random out_ready. It holds DONE for `stall` cycles, then
  // consumes. Called at #1 after a rising edge and returns at the same phase.
  task automatic do_op8(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit s, input int stall);
    int g, lat;
    logic [2*W-1:0] held;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(ref_mul(W, 32'(a), 32'(b), s));
    @(posedge clk); #1;                           // E0: accepted
    check("throughput_ok", 64'((cyc - last_acc_cyc) >= W + 2), 64'd1);
    last_acc_cyc = cyc;
    lat = 0;
    while (!out_valid && lat < 100) begin
      check("busy_in_ready", 64'(in_ready), 64'd0);
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_signed = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; lat++;
    end
    check("latency", 64'(lat), 64'(W));
    out_ready = 1'b0;
    held = out_product;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a     = W'($urandom);
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_hold", 64'(out_product), 64'(held));
    end
    out_ready = 1'b1;
    if (exp_q.size() > 0) check("product", 64'(out_product), exp_q.pop_front());
    else check("sb_empty", 64'(exp_q.size()), 64'd1);
    @(posedge clk); #1;                           // consumption edge
    check("consumed_valid", 64'(out_valid), 64'd0);
    check("consumed_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic do_op16(input logic [WH-1:0] a, input logic [WH-1:0] b, input bit s);
    int lat;
    h_in_a = a; h_in_b = b; h_in_signed = s; h_in_valid = 1'b1;
    check("h_accept_ready", 64'(h_in_ready), 64'd1);
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 0;
    while (!h_out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("h_latency", 64'(lat), 64'(WH));
    check("h_product", 64'(h_out_product), ref_mul(WH, 32'(a), 32'(b), s));
    h_out_ready = 1'b1;
    @(posedge clk); #1;
    check("h_consumed", 64'(h_out_valid), 64'd0);
    h_out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    in_valid = 0; in_a = '0; in_b = '0; in_signed = 0; out_ready = 0;
    h_in_valid = 0; h_in_a = '0; h_in_b = '0; h_in_signed = 0; h_out_ready = 0;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", 64'(out_product), 64'd0);
    check("h_rst_product", 64'(h_out_product), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases
    do_op8(8'hFF, 8'hFF, 1'b0, 0);               // 0xFE01
    check("dir_255x255", 64'(out_product), 64'hFE01);
    do_op8(8'h80, 8'h80, 1'b1, 0);               // 0x4000
    check("dir_m128xm128", 64'(out_product), 64'h4000);
    do_op8(8'hFF, 8'h7F, 1'b1, 0);               // 0xFF81
    check("dir_m1x127", 64'(out_product), 64'hFF81);
    do_op8(8'h80, 8'h7F, 1'b1, 0);               // 0xC080
    check("dir_m128x127", 64'(out_product), 64'hC080);
    do_op8(8'h00, 8'hFB, 1'b1, 0);               // 0x0000
    check("dir_0xm5", 64'(out_product), 64'h0000);
    do_op8(8'd3, 8'd5, 1'b0, 6);                 // 0x000F with a 6-cycle stall
    check("dir_3x5", 64'(out_product), 64'h000F);

    // Reset in the middle of 200*200, after BUSY edge E4
    in_a = 8'd200; in_b = 8'd200; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;                          // E0
    in_valid = 1'b0;
    repeat (4) @(posedge clk);                   // E1..E4
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_product", 64'(out_product), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op8(8'd2, 8'd3, 1'b0, 0);
    check("post_abort_2x3", 64'(out_product), 64'h0006);

    // WIDTH=16 corner cases
    do_op16(16'hFFFF, 16'hFFFF, 1'b0);
    check("h_ffff_sq", 64'(h_out_product), 64'hFFFE0001);
    do_op16(16'h8000, 16'h8000, 1'b1);
    check("h_8000_sq", 64'(h_out_product), 64'h40000000);
    do_op16(16'(($urandom)), 16'(($urandom)), 1'b1);

    // Random stream
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] ra, rb;
      int sel;
      sel = $urandom_range(0, 7);
      ra = W'($urandom);
      rb = W'($urandom);
      if (sel == 0) ra = 8'h80;
      if (sel == 1) rb = 8'h80;
      if (sel == 2) ra = 8'hFF;
      do_op8(ra, rb, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_mul_hs.md
# seq_mul_hs

Parametrised sequential shift-add multiplier with valid/ready handshakes on both sides and per-operation signed/unsigned mode. It computes one multiplier bit per cycle and returns the full double-width product. The result is held stable until the consumer accepts it. It is the general-purpose successor of the fixed 8-bit free-running multiplier and sits between a producer and a consumer that both use valid/ready streams.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has an operation on in_a/in_b/in_signed
- in_ready  output  1  block can accept an operation (high only in IDLE)
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- in_signed  input  1  1: operands and product are two's complement; 0: unsigned
- out_valid  output  1  out_product holds a completed result
- out_ready  input  1  consumer accepts the result
- out_product  output  2*WIDTH  product

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid && in_ready, capture the operands and go to BUSY with bit counter = 0.
  - If in_signed=1, capture |in_a| and |in_b| as WIDTH-bit unsigned magnitudes; |-2^(WIDTH-1)| = 2^(WIDTH-1) is exact.
  - Record neg = in_signed & (a_msb ^ b_msb).
- BUSY: in_ready=0, out_valid=0; in_* are ignored.
  - Each edge:
    - If the multiplier LSB = 1, add the shifted multiplicand (2*WIDTH bits) to the accumulator.
    - Shift the multiplicand left by 1 and the multiplier right by 1.
    - Increment the counter.
  - When counter == WIDTH-1, that edge performs the last add, loads out_product, and enters DONE.
  - out_product = neg ? -(acc_final) : acc_final, computed modulo 2^(2*WIDTH).
- DONE: out_valid=1, in_ready=0.
  - out_product is stable.
  - On out_valid && out_ready, go to IDLE.
- Arithmetic:
  - Unsigned results range 0..(2^WIDTH-1)^2.
  - Signed results range -2^(2W-2)+2^(W-1) .. 2^(2W-2).
  - Both ranges fit in 2*WIDTH bits; no overflow is possible and no flag exists.
  - The accumulator never exceeds the final magnitude, and it is monotonically non-decreasing during BUSY.
- out_product is written only on BUSY→DONE. After consumption it keeps the last result; it is meaningful only while out_valid=1.
- Reset (any state, any time):
  - State goes to IDLE immediately.
  - out_valid=0 and out_product=0; the accumulator and counter are cleared.
  - Any in-flight operation is discarded.
  - in_ready=1 while rst_n=0.
- There is no early termination. Latency does not depend on operand values.

## Timing
- Reset values: in_ready=1, out_valid=0, out_product=0.
- Acceptance at edge E0 leads to BUSY edges E1..EWIDTH. EWIDTH enters DONE, so out_valid is high from E_WIDTH until acceptance: WIDTH cycles of latency.
- in_ready falls in the cycle after E0. A second in_valid is never accepted before the previous result is consumed.
- Earliest consumption is at E(WIDTH+1), which returns to IDLE. The next acceptance is at E(WIDTH+2), giving a peak throughput of one operation per WIDTH+2 cycles.
- out_ready held low stalls DONE indefinitely. out_product and out_valid must not change during the stall.
- out_ready while out_valid=0 has no effect.
- in_valid while in_ready=0 has no effect. The producer may drop or change in_* freely.
- If rst_n is asserted on the same edge as a handshake, reset wins and nothing is captured.
- Reset deassertion is synchronised externally. The first acceptance is possible on the first edge with rst_n=1.

## Test plan
- WIDTH=8, unsigned 255*255 accepted at E0 → out_valid rises at E8; out_product=0xFE01 (65025); out_ready=1 returns to IDLE at E9; in_ready=1 at E9.
- WIDTH=8 signed: -128*-128 → 0x4000; -1*127 → 0xFF81; -128*127 → 0xC080; 0*-5 → 0x0000; each with latency 8.
- WIDTH=8, 3*5 unsigned with out_ready=0 for 6 cycles after out_valid → out_product stays 0x000F and out_valid stays 1 throughout. Raising out_ready consumes the result in one cycle. A new in_valid raised during BUSY/DONE is not accepted until IDLE.
- WIDTH=8, rst_n pulsed low at BUSY edge E4 of 200*200 → out_valid=0, out_product=0 and in_ready=1 asynchronously. A following 2*3 completes with 0x0006 and no residue from the aborted operation.
- WIDTH=16, 0xFFFF*0xFFFF unsigned → 0xFFFE0001 at E16; signed 0x8000*0x8000 → 0x40000000.
- Random back-to-back stream, 1000 operations, random in_signed and stalls → every product matches the reference model. Throughput is never better than WIDTH+2 cycles per operation.
